// File: rtl/bus_reg_writeback_pkg.sv
// Shared CPU datapath constants for the GP register write-back slice.
// Contents:
//   CPU_DATA_W   - register and bus width
//   CPU_SEL_W    - register select width
//   CPU_NUM_REGS - number of GP registers (2**CPU_SEL_W)
//   reg_sel_t    - register select type
//   satInc8      - saturating 8-bit increment used by debug counters
package bus_reg_writeback_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_SEL_W    = 4;
  localparam int CPU_NUM_REGS = 16;

  typedef logic [CPU_SEL_W-1:0] reg_sel_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bus_reg_writeback_gp_reg.sv
// Single general-purpose register with asynchronous active-low clear
// and a synchronous load enable.
// Ports:
//   i_clk   - rising-edge clock
//   i_clrN  - asynchronous active-low clear
//   i_load  - load i_d at the next rising edge
//   i_d     - data to load
//   o_q     - registered contents
module gp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_clrN,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Hold the value until a load is requested; clear wins at any time.
  always_ff @(posedge i_clk or negedge i_clrN) begin
    if (!i_clrN) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_reg_writeback.sv
// Write-back side of the GP register file. Captures a word from the
// shared bus into one of NUM_REGS registers, drives all register
// contents back to the bus mux, and keeps a busy scoreboard so the
// control unit can reserve a destination and stall reads of stale data.
// Ports:
//   clk, clr_n            - clock and asynchronous active-low reset
//   wr_valid/wr_ready     - write handshake, wr_sel selects, wr_data is BusMuxOut
//   rsv_valid/rsv_ready   - reservation handshake, rsv_sel selects
//   hold                  - freezes writes and reservations
//   gp_outputs            - flattened registers, reg i at [i*DATA_W +: DATA_W]
//   busy                  - scoreboard, bit i = register i has a pending write
//   wr_count              - saturating count of accepted writes
module bus_reg_writeback
  import bus_reg_writeback_pkg::*;
#(
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int DATA_W   = CPU_DATA_W,
  parameter int SEL_W    = CPU_SEL_W,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_valid,
  output logic                       rsv_ready,
  input  logic [SEL_W-1:0]           rsv_sel,
  input  logic                       hold,
  output logic [NUM_REGS*DATA_W-1:0] gp_outputs,
  output logic [NUM_REGS-1:0]        busy,
  output logic [7:0]                 wr_count
);

  logic                r_busyUnused;
  logic [NUM_REGS-1:0] r_busy;
  logic [7:0]          r_wrCount;
  logic                w_wrAcc;
  logic                w_rsvAcc;
  logic [NUM_REGS-1:0] w_loadEn;
  logic [NUM_REGS-1:0] w_rsvMask;

  // Register 0 never becomes busy when it is hardwired, so the plain
  // busy lookup already makes a reservation of it always ready.
  assign wr_ready  = ~hold;
  assign rsv_ready = ~hold & ~r_busy[rsv_sel];
  assign w_wrAcc   = wr_valid & wr_ready;
  assign w_rsvAcc  = rsv_valid & rsv_ready;

  // One-hot decode of the accepted write and reservation targets.
  always_comb begin
    w_loadEn  = '0;
    w_rsvMask = '0;
    if (w_wrAcc) begin
      w_loadEn[wr_sel] = 1'b1;
    end
    if (w_rsvAcc) begin
      w_rsvMask[rsv_sel] = 1'b1;
    end
    if (ZERO_R0) begin
      w_rsvMask[0] = 1'b0;
    end
  end

  // Scoreboard: a landing write clears its bit, a new reservation sets
  // it. Set is applied last so a same-cycle reservation for a newer
  // producer keeps the register busy.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_loadEn) | w_rsvMask;
    end
  end

  // Debug count of accepted writes, including discarded register-0 writes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wrCount <= '0;
    end else if (w_wrAcc) begin
      r_wrCount <= satInc8(r_wrCount);
    end
  end

  // Register array; a hardwired register 0 is simply a constant slice.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    if (i == 0 && ZERO_R0) begin : g_zero
      assign gp_outputs[i*DATA_W +: DATA_W] = '0;
    end else begin : g_reg
      gp_reg #(
        .DATA_W (DATA_W)
      ) u_gpReg (
        .i_clk  (clk),
        .i_clrN (clr_n),
        .i_load (w_loadEn[i]),
        .i_d    (wr_data),
        .o_q    (gp_outputs[i*DATA_W +: DATA_W])
      );
    end
  end

  assign r_busyUnused = 1'b0;
  assign busy         = r_busy;
  assign wr_count     = r_wrCount;

endmodule

// File: tb/tb_bus_reg_writeback.sv
// Directed self-checking bench for bus_reg_writeback. A small expected
// state (register image, busy mask, write count) is updated by hand
// alongside each stimulus step and compared against the DUT.
module tb_bus_reg_writeback;

  localparam int NR = 16;
  localparam int DW = 32;

  logic            clk;
  logic            clr_n;
  logic            wr_valid;
  logic            wr_ready;
  logic [3:0]      wr_sel;
  logic [DW-1:0]   wr_data;
  logic            rsv_valid;
  logic            rsv_ready;
  logic [3:0]      rsv_sel;
  logic            hold;
  logic [NR*DW-1:0] gp_outputs;
  logic [NR-1:0]   busy;
  logic [7:0]      wr_count;

  logic [NR*DW-1:0] expGp;
  logic [NR-1:0]    expBusy;
  logic [7:0]       expCount;

  int checks;
  int failures;

  bus_reg_writeback dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .rsv_valid  (rsv_valid),
    .rsv_ready  (rsv_ready),
    .rsv_sel    (rsv_sel),
    .hold       (hold),
    .gp_outputs (gp_outputs),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [NR*DW-1:0] obs,
                             input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive all request inputs, then let combinational readies settle.
  task automatic applyStimulus(input logic wv, input logic [3:0] ws,
                               input logic [DW-1:0] wd, input logic rv,
                               input logic [3:0] rs, input logic h);
    wr_valid  = wv;
    wr_sel    = ws;
    wr_data   = wd;
    rsv_valid = rv;
    rsv_sel   = rs;
    hold      = h;
    #1;
  endtask

  // Advance past the next rising edge and sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_gp"}, gp_outputs, expGp);
    checkOutput({tag, "_busy"}, {{(NR*DW-NR){1'b0}}, busy}, {{(NR*DW-NR){1'b0}}, expBusy});
    checkOutput({tag, "_count"}, {{(NR*DW-8){1'b0}}, wr_count}, {{(NR*DW-8){1'b0}}, expCount});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expGp    = '0;
    expBusy  = '0;
    expCount = '0;
    clr_n    = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    checkState("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // Basic write to register 3
    applyStimulus(1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 1'b0);
    checkOutput("wr_ready_idle", {511'b0, wr_ready}, {511'b0, 1'b1});
    checkOutput("no_bypass", gp_outputs, expGp);
    tick();
    expGp[3*DW +: DW] = 32'h12345678;
    expCount = 8'd1;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    checkState("write3");

    // Register 0 discards data but still counts the write
    applyStimulus(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0);
    checkOutput("r0_wr_ready", {511'b0, wr_ready}, {511'b0, 1'b1});
    tick();
    expCount = 8'd2;
    checkState("r0_discard");

    // Register 5 gets a value used later by the mid-run reset
    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0);
    tick();
    expGp[5*DW +: DW] = 32'hDEADBEEF;
    expCount = 8'd3;
    checkState("write5");

    // Reserve 7, then a second reservation of 7 must stall
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0);
    checkOutput("rsv7_ready", {511'b0, rsv_ready}, {511'b0, 1'b1});
    tick();
    expBusy = 16'h0080;
    checkState("rsv7");
    checkOutput("rsv7_stall", {511'b0, rsv_ready}, {511'b0, 1'b0});
    tick();
    checkState("rsv7_held");

    // Write 7 lands and frees the scoreboard bit
    applyStimulus(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 4'd7, 1'b0);
    tick();
    expGp[7*DW +: DW] = 32'hA5A5A5A5;
    expBusy = 16'h0000;
    expCount = 8'd4;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd7, 1'b0);
    checkState("write7");
    checkOutput("rsv7_free", {511'b0, rsv_ready}, {511'b0, 1'b1});

    // Reserving register 0 is always ready and never sets busy
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 1'b0);
    checkOutput("rsv0_ready", {511'b0, rsv_ready}, {511'b0, 1'b1});
    tick();
    checkState("rsv0");

    // Same-cycle write and reservation of register 4: busy ends set
    applyStimulus(1'b1, 4'd4, 32'h00000042, 1'b1, 4'd4, 1'b0);
    tick();
    expGp[4*DW +: DW] = 32'h00000042;
    expBusy = 16'h0010;
    expCount = 8'd5;
    checkState("simul_same");

    // Write 4 and reserve 9 independently
    applyStimulus(1'b1, 4'd4, 32'h00000099, 1'b1, 4'd9, 1'b0);
    tick();
    expGp[4*DW +: DW] = 32'h00000099;
    expBusy = 16'h0200;
    expCount = 8'd6;
    checkState("simul_diff");

    // Hold blocks both handshakes and freezes state
    applyStimulus(1'b1, 4'd2, 32'h11111111, 1'b1, 4'd3, 1'b1);
    checkOutput("hold_wr_ready", {511'b0, wr_ready}, {511'b0, 1'b0});
    checkOutput("hold_rsv_ready", {511'b0, rsv_ready}, {511'b0, 1'b0});
    tick();
    tick();
    checkState("hold");

    // Releasing hold resumes with the same requests
    applyStimulus(1'b1, 4'd2, 32'h11111111, 1'b1, 4'd3, 1'b0);
    tick();
    expGp[2*DW +: DW] = 32'h11111111;
    expBusy = 16'h0208;
    expCount = 8'd7;
    checkState("unhold");

    // Asynchronous reset in the middle of a cycle with a write pending
    applyStimulus(1'b1, 4'd6, 32'hCAFEF00D, 1'b1, 4'd6, 1'b0);
    clr_n = 1'b0;
    #1;
    expGp = '0;
    expBusy = '0;
    expCount = '0;
    checkState("async_reset");
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    checkState("after_reset");

    // Back-to-back writes to register 1 until the counter saturates
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, 4'd1, 32'(k + 1), 1'b0, 4'd0, 1'b0);
      tick();
      if (k == 253) begin
        checkOutput("count_254", {504'b0, wr_count}, {504'b0, 8'd254});
      end
    end
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);
    expGp[1*DW +: DW] = 32'd300;
    expCount = 8'd255;
    checkState("saturate");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_reg_writeback.md
Name: bus_reg_writeback

Overview:
- Write-side counterpart of the general-purpose bus mux: captures a word from the shared bus into one of 16 GP registers.
- Drives the register contents back to the mux inputs.
- Keeps a busy scoreboard so the control unit can reserve a destination register and stall reads of stale data until the write-back lands.
- Sits between the bus mux output and the GP register outputs in the datapath.

Parameters:
- NUM_REGS, 16, number of GP registers; must equal 2**SEL_W.
- DATA_W, 32, register and bus width.
- SEL_W, 4, register select width.
- ZERO_R0, 1, when 1 register 0 reads as 0, ignores writes and never becomes busy.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request this cycle.
- wr_ready  out  1  unit accepts a write this cycle.
- wr_sel  in  SEL_W  destination register of the write.
- wr_data  in  DATA_W  write data, connected to BusMuxOut.
- rsv_valid  in  1  reservation request (mark destination busy).
- rsv_ready  out  1  reservation can be accepted this cycle.
- rsv_sel  in  SEL_W  register to reserve.
- hold  in  1  freeze all writes and reservations (single-step/debug).
- gp_outputs  out  NUM_REGS*DATA_W  flattened registers; register i occupies bits [i*DATA_W +: DATA_W], feeding gp_output0..15 of the mux.
- busy  out  NUM_REGS  scoreboard; bit i set means register i has a pending write.
- wr_count  out  8  saturating count of accepted writes (debug).

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is asynchronous and active-low on clr_n.
  - While clr_n=0: all registers = 0, busy = 0, wr_count = 0.
  - Outputs are registered except wr_ready and rsv_ready.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready.
  - wr_ready = ~hold (combinational).
  - Accepted data appears on gp_outputs the cycle after the accepting edge (latency 1).
  - No write-through or bypass to gp_outputs in the same cycle.
- Register 0:
  - With ZERO_R0=1, a write to register 0 is accepted (handshake completes, wr_count increments) but the data is discarded.
  - Register 0 slice of gp_outputs is constant 0.
- Reservation handshake:
  - A reservation is accepted when rsv_valid && rsv_ready.
  - rsv_ready = ~hold && ~busy[rsv_sel] (combinational).
  - Reserving an already-busy register stalls (rsv_ready=0) until its write lands.
  - Accepted reservation sets busy[rsv_sel] at the edge.
  - With ZERO_R0=1, rsv_sel=0 is always ready and never sets busy.
- Busy clear:
  - An accepted write clears busy[wr_sel] at the edge.
  - A write to a register that is not busy is legal and leaves busy unchanged.
- Simultaneous events, same cycle:
  - Write and reservation to the same register (possible only when it was not busy): data is written and busy ends SET, because the reservation is for a newer producer.
  - Write and reservation to different registers: both take effect independently.
- wr_count:
  - Increments by 1 per accepted write.
  - Saturates at 255; no wrap-around.
- hold:
  - hold=1 forces both readies low; registers, busy and wr_count are unchanged.
  - Deasserting hold resumes on the next cycle with no lost state.
- Reset mid-operation:
  - clr_n low while busy bits are set or a handshake is in flight clears everything immediately.
  - A write pending at reset is lost; no partial update.
- X/protocol:
  - wr_sel and rsv_sel are don't-care when the corresponding valid is low.
  - Valid may drop without acceptance; no request state is retained.

Decomposition:
- Shared package (cpu_pkg): DATA_W=32, SEL_W=4, NUM_REGS=16 constants; typedef for a register select.
- One sub-module is natural: gp_reg, a single DATA_W register with async active-low clear and load enable, instanced NUM_REGS times (register 0 conditional on ZERO_R0).
- The decoder, scoreboard and counter stay in the top module.

Test Plan:
- Reset: clr_n=0 mid-simulation after writing register 5 = 0xDEADBEEF -> all gp_outputs, busy and wr_count read 0 immediately (asynchronous), and stay 0 after release.
- Basic write: wr_valid=1, wr_sel=3, wr_data=0x12345678 for one cycle -> gp_outputs register 3 = 0x12345678 on the next cycle; all other registers unchanged; wr_count=1.
- R0 discard: write 0xFFFFFFFF to register 0 -> register 0 remains 0, wr_ready=1, wr_count increments.
- Scoreboard: reserve register 7 -> busy=0x0080; a second reserve of 7 sees rsv_ready=0; write register 7 = 0xA5A5A5A5 -> busy=0x0000 and rsv_ready returns to 1.
- Simultaneous: with register 4 not busy, same-cycle write of register 4 = 0x00000042 and reserve of register 4 -> register 4 = 0x42 and busy[4]=1 afterward.
- Hold and saturation: hold=1 with wr_valid=1 -> wr_ready=0 and no state change; then 300 back-to-back writes -> wr_count=255.
